// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer: FSM states, opcodes that
// match the ALU's FN table, and instruction field positions.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    T1    = 3'd2,
    T2    = 3'd3,
    T3    = 3'd4
  } state_t;

  localparam logic [3:0] LOAD = 4'b0000;
  localparam logic [3:0] MOV  = 4'b0001;
  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b0011;
  localparam logic [3:0] INV  = 4'b0100;
  localparam logic [3:0] FLP  = 4'b0101;
  localparam logic [3:0] AND  = 4'b0110;
  localparam logic [3:0] OR   = 4'b0111;
  localparam logic [3:0] XOR  = 4'b1000;
  localparam logic [3:0] LSL  = 4'b1001;
  localparam logic [3:0] LSR  = 4'b1010;
  localparam logic [3:0] ASR  = 4'b1011;

  localparam int OPC_LSB = 6;
  localparam int RX_LSB  = 3;
  localparam int RY_LSB  = 0;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= ADD) && (op <= ASR);
  endfunction

  // INV and FLP take no second operand, so nothing drives the bus in T2.
  function automatic logic is_unary_op(input logic [3:0] op);
    return (op == INV) || (op == FLP);
  endfunction

endpackage

// File: rtl/alu_ctrl_unit_reg_sel_dec.sv
// Binary-to-one-hot register select decoder with enable.
module reg_sel_dec #(
  parameter int NREG = 8
) (
  input  logic                    en,
  input  logic [$clog2(NREG)-1:0] sel,
  output logic [NREG-1:0]         onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/alu_ctrl_unit.sv
// Instruction sequencer driving ALU strobes and register enables over 1-4 steps.
// Optional ALU_CTRL_ERR_FLAG_EN adds a sticky ERR output for reserved opcodes.
module alu_ctrl_unit
  import alu_ctrl_pkg::*;
#(
  parameter int N    = 10,
  parameter int NREG = 8,
  parameter int FNW  = 4
) (
  input  logic            CLKb,
  input  logic            RST,
  input  logic [N-1:0]    INSTR,
  input  logic            PEXEC,
  output logic            IRin,
  output logic [FNW-1:0]  FN,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            DINout,
  output logic            DONE
`ifdef ALU_CTRL_ERR_FLAG_EN
  ,
  output logic            ERR
`endif
);

  localparam int SW = $clog2(NREG);

  state_t         state;
  logic [N-1:0]   ir;
  logic [3:0]     op;
  logic [SW-1:0]  rx, ry;
  logic           rin_en, rout_en;
  logic [SW-1:0]  rin_sel, rout_sel;

  assign op = ir[OPC_LSB +: 4];
  assign rx = ir[RX_LSB +: SW];
  assign ry = ir[RY_LSB +: SW];

  always_ff @(posedge CLKb or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      case (state)
        IDLE:    if (PEXEC) state <= FETCH;
        FETCH: begin
          ir    <= INSTR;
          state <= T1;
        end
        T1:      state <= is_alu_op(op) ? T2 : IDLE;
        T2:      state <= T3;
        T3:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode: every strobe is a function of state and IR only.
  always_comb begin
    IRin     = 1'b0;
    FN       = '0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    DINout   = 1'b0;
    DONE     = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rin_sel  = rx;
    rout_sel = ry;
    case (state)
      FETCH: IRin = 1'b1;
      T1: begin
        if (op == LOAD) begin
          DINout = 1'b1;
          rin_en = 1'b1;
          DONE   = 1'b1;
        end else if (op == MOV) begin
          rout_en = 1'b1;
          rin_en  = 1'b1;
          DONE    = 1'b1;
        end else if (is_alu_op(op)) begin
          rout_en  = 1'b1;
          rout_sel = rx;
          Ain      = 1'b1;
        end else begin
          DONE = 1'b1;
        end
      end
      T2: begin
        FN      = FNW'(op);
        Gin     = 1'b1;
        rout_en = !is_unary_op(op);
      end
      T3: begin
        FN     = FNW'(op);
        Gout   = 1'b1;
        rin_en = 1'b1;
        DONE   = 1'b1;
      end
      default: ;
    endcase
  end

  reg_sel_dec #(.NREG(NREG)) u_rin_dec (
    .en     (rin_en),
    .sel    (rin_sel),
    .onehot (Rin)
  );

  reg_sel_dec #(.NREG(NREG)) u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (Rout)
  );

`ifdef ALU_CTRL_ERR_FLAG_EN
  // Sticky until reset; latched on the edge that leaves T1 of a reserved op.
  always_ff @(posedge CLKb or posedge RST) begin
    if (RST) ERR <= 1'b0;
    else if (state == T1 && op > ASR) ERR <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed bench for alu_ctrl_unit with hand-computed strobe expectations.
module tb_alu_ctrl_unit;

  logic       CLKb = 1'b0;
  logic       RST;
  logic [9:0] INSTR;
  logic       PEXEC;
  logic       IRin, Ain, Gin, Gout, DINout, DONE;
  logic [3:0] FN;
  logic [7:0] Rin, Rout;
`ifdef ALU_CTRL_ERR_FLAG_EN
  logic       ERR;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  alu_ctrl_unit dut (
    .CLKb   (CLKb),
    .RST    (RST),
    .INSTR  (INSTR),
    .PEXEC  (PEXEC),
    .IRin   (IRin),
    .FN     (FN),
    .Ain    (Ain),
    .Gin    (Gin),
    .Gout   (Gout),
    .Rin    (Rin),
    .Rout   (Rout),
    .DINout (DINout),
    .DONE   (DONE)
`ifdef ALU_CTRL_ERR_FLAG_EN
    ,
    .ERR    (ERR)
`endif
  );

  always #5 CLKb = ~CLKb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLKb);
    #1;
  endtask

  // Strobe bundle: {IRin, Ain, Gin, Gout, DINout, DONE}
  function automatic logic [5:0] strobes();
    return {IRin, Ain, Gin, Gout, DINout, DONE};
  endfunction

  // Output invariants, sampled every falling edge.
  always @(negedge CLKb) begin
    if (DONE) done_cnt++;
    chk("rin_onehot0", {31'd0, $onehot0(Rin)}, 32'd1);
    chk("rout_onehot0", {31'd0, $onehot0(Rout)}, 32'd1);
    chk("one_bus_driver", {31'd0, $onehot0({|Rout, Gout, DINout})}, 32'd1);
  end

  initial begin
    RST = 1'b1; PEXEC = 1'b0; INSTR = '0;
    #2;
    chk("rst_strobes", strobes(), 6'b0);
    chk("rst_fn", FN, 4'h0);
    chk("rst_rin_rout", {Rin, Rout}, 16'h0);
    tick; tick;
    RST = 1'b0;

    // Idle without a start request
    tick;
    chk("idle_hold", strobes(), 6'b0);

    // LOAD R3
    INSTR = 10'b0000_011_000; PEXEC = 1'b1;
    tick;
    chk("load_fetch", strobes(), 6'b100000);
    PEXEC = 1'b0;
    tick;
    chk("load_t1", strobes(), 6'b000011);
    chk("load_t1_rin", Rin, 8'h08);
    chk("load_t1_rout", Rout, 8'h00);
    tick;
    chk("load_idle", strobes(), 6'b0);

    // ADD R1, R2
    INSTR = 10'b0010_001_010; PEXEC = 1'b1;
    tick;
    chk("add_fetch", strobes(), 6'b100000);
    PEXEC = 1'b0;
    tick;
    chk("add_t1", strobes(), 6'b010000);
    chk("add_t1_rout", Rout, 8'h02);
    chk("add_t1_fn", FN, 4'h0);
    tick;
    chk("add_t2", strobes(), 6'b001000);
    chk("add_t2_rout", Rout, 8'h04);
    chk("add_t2_fn", FN, 4'h2);
    tick;
    chk("add_t3", strobes(), 6'b000101);
    chk("add_t3_rin", Rin, 8'h02);
    chk("add_t3_rout", Rout, 8'h00);
    chk("add_t3_fn", FN, 4'h2);
    tick;
    chk("add_idle_fn", FN, 4'h0);

    // FLP R7 (unary: no operand on the bus in T2)
    INSTR = 10'b0101_111_000; PEXEC = 1'b1;
    tick;
    PEXEC = 1'b0;
    tick;
    chk("flp_t1_rout", Rout, 8'h80);
    tick;
    chk("flp_t2", strobes(), 6'b001000);
    chk("flp_t2_rout", Rout, 8'h00);
    chk("flp_t2_fn", FN, 4'h5);
    tick;
    chk("flp_t3", strobes(), 6'b000101);
    chk("flp_t3_rin", Rin, 8'h80);
    tick;

    // Reset in the middle of ADD's T2
    INSTR = 10'b0010_001_010; PEXEC = 1'b1;
    tick;
    PEXEC = 1'b0;
    tick; tick;
    chk("rst_mid_pre_gin", Gin, 1'b1);
    RST = 1'b1;
    #1;
    chk("rst_mid_strobes", strobes(), 6'b0);
    chk("rst_mid_fn", FN, 4'h0);
    chk("rst_mid_rout", Rout, 8'h00);
    tick;
    chk("rst_mid_no_done", strobes(), 6'b0);
    RST = 1'b0;
    tick;
    chk("rst_mid_idle", strobes(), 6'b0);

    // Back-to-back: ADD then MOV R3,R5 with PEXEC held high
    INSTR = 10'b0010_001_010; PEXEC = 1'b1;
    tick;
    chk("b2b_fetch1", strobes(), 6'b100000);
    tick;
    INSTR = 10'b0001_011_101;
    chk("b2b_t1", strobes(), 6'b010000);
    tick;
    chk("b2b_t2_fn", FN, 4'h2);
    chk("b2b_t2_rout", Rout, 8'h04);
    tick;
    chk("b2b_t3", strobes(), 6'b000101);
    tick;
    chk("b2b_idle", strobes(), 6'b0);
    tick;
    chk("b2b_fetch2", strobes(), 6'b100000);
    tick;
    chk("b2b_mov_t1", strobes(), 6'b000001);
    chk("b2b_mov_rout", Rout, 8'h20);
    chk("b2b_mov_rin", Rin, 8'h08);
    PEXEC = 1'b0;
    tick;
    chk("b2b_end_idle", strobes(), 6'b0);

    // Reserved opcode 1110
    INSTR = 10'b1110_000_000; PEXEC = 1'b1;
    tick;
    PEXEC = 1'b0;
    tick;
    chk("rsv_t1", strobes(), 6'b000001);
    chk("rsv_t1_rin_rout", {Rin, Rout}, 16'h0);
    tick;
    chk("rsv_idle", strobes(), 6'b0);
`ifdef ALU_CTRL_ERR_FLAG_EN
    chk("rsv_err_set", ERR, 1'b1);
`endif

    // MOV R4,R4: legal no-op write
    INSTR = 10'b0001_100_100; PEXEC = 1'b1;
    tick;
    PEXEC = 1'b0;
    tick;
    chk("mov_same_t1", strobes(), 6'b000001);
    chk("mov_same_rin", Rin, 8'h10);
    chk("mov_same_rout", Rout, 8'h10);
    tick;
`ifdef ALU_CTRL_ERR_FLAG_EN
    chk("err_sticky", ERR, 1'b1);
    RST = 1'b1;
    #1;
    chk("err_cleared", ERR, 1'b0);
    RST = 1'b0;
`endif
    tick;
    chk("done_count", done_cnt, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_unit.md
Name: alu_ctrl_unit

Overview:
- Control sequencer directly upstream of the multi-stage ALU.
- Captures a 10-bit instruction and decodes it.
- Drives the ALU's Ain/Gin/Gout/FN strobes, the register-file Rin/Rout one-hot enables and the data-in bus driver, over a 1-4 step sequence.
- Reports completion with DONE.

Parameters:
- N, 10, instruction and data bus width.
- NREG, 8, number of general registers; RX/RY fields are clog2(NREG)=3 bits.
- FNW, 4, opcode/FN field width.

Ports:
- CLKb  in  1  system clock; all state updates on posedge CLKb, so strobes are stable at the ALU's negedge sample.
- RST  in  1  asynchronous, active-high reset.
- INSTR  in  N  instruction: [9:6] opcode, [5:3] RX, [2:0] RY.
- PEXEC  in  1  start request, sampled on posedge CLKb.
- IRin  out  1  instruction register load strobe (FETCH).
- FN  out  FNW  ALU function code.
- Ain  out  1  ALU A-register load.
- Gin  out  1  ALU G-register load.
- Gout  out  1  ALU result drives bus.
- Rin  out  NREG  one-hot register load enables.
- Rout  out  NREG  one-hot register bus-drive enables.
- DINout  out  1  external data-in drives bus.
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state): state=IDLE, IR=0, all outputs 0, FN=4'b0000.
- Opcodes:
  - 0000 LOAD: RX <= DIN.
  - 0001 MOV: RX <= RY.
  - 0010-1011: ALU ops, matching the ALU's FN table (ADD, SUB, INV, FLP, AND, OR, XOR, LSL, LSR, ASR).
  - 1100-1111: reserved.
- States: IDLE, FETCH, T1, T2, T3.
- IDLE:
  - PEXEC=1 -> FETCH.
  - PEXEC=0 -> stay.
- FETCH:
  - IRin=1; IR <= INSTR at the clock edge leaving FETCH.
  - Always -> T1.
- T1, by IR opcode:
  - LOAD: DINout=1, Rin[RX]=1, DONE=1 -> IDLE.
  - MOV: Rout[RY]=1, Rin[RX]=1, DONE=1 -> IDLE. RX==RY is legal and is a no-op write.
  - ALU op: Rout[RX]=1, Ain=1 -> T2.
  - Reserved: DONE=1, no other strobes -> IDLE.
- T2:
  - FN=opcode and Gin=1.
  - Rout[RY]=1 for binary and shift ops. For INV and FLP, Rout=0 (bus undriven; the ALU ignores its operand).
  - -> T3.
- T3:
  - FN held, Gout=1, Rin[RX]=1, DONE=1 -> IDLE.
- Outside T2/T3, FN=0000 (ALU default, result bus undriven).
- Latency from PEXEC sample to DONE: 2 cycles for LOAD/MOV/reserved, 4 cycles for ALU ops.
- Back-to-back: PEXEC high in the DONE cycle is not seen. The next start is taken in IDLE on the following edge.
- PEXEC in any state other than IDLE is ignored; no queuing.
- Output invariants, every cycle:
  - Rin and Rout are each zero or one-hot.
  - At most one bus driver is active (Rout, Gout, DINout mutually exclusive).
  - DONE is high for exactly one cycle per instruction.
- All outputs are decoded combinationally from the state and IR (Moore). INSTR changes after FETCH have no effect.
- RST asserted mid-sequence: immediate return to IDLE, all strobes drop asynchronously, no DONE.

Optional Feature:
- Macro: ALU_CTRL_ERR_FLAG_EN.
- Defined:
  - Adds output ERR (1 bit), reset to 0.
  - ERR is set in the T1 cycle of a reserved opcode and is sticky until RST.
  - Reserved opcodes still complete with DONE.
- Undefined: no ERR port; reserved opcodes silently complete with DONE.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - the state enum (IDLE, FETCH, T1, T2, T3);
  - opcode localparams LOAD, MOV, ADD..ASR, shared with the ALU;
  - field-position constants for opcode, RX and RY.
- One sub-module, reg_sel_dec: a clog2(NREG)-to-NREG one-hot decoder with enable, instantiated twice (Rin, Rout).

Test Plan:
- Reset mid-T2 of ADD: assert RST -> next sample shows state IDLE, Gin=0, Rout=0, FN=0, no DONE.
- LOAD: INSTR=10'b0000_011_000, PEXEC=1 -> FETCH IRin=1, then T1 DINout=1, Rin=8'b0000_1000, DONE=1; total 2 cycles.
- ADD: INSTR=10'b0010_001_010 -> T1 Rout=0000_0010 with Ain; T2 Rout=0000_0100, FN=0010, Gin; T3 Gout, Rin=0000_0010, DONE. No overlap of bus drivers.
- FLP: INSTR=10'b0101_111_000 -> T2 Rout=0, FN=0101, Gin=1; T3 Rin=1000_0000, DONE=1.
- PEXEC held high continuously with ADD then MOV: second instruction is fetched only after IDLE; PEXEC in T1-T3 is ignored. DONE count equals the instruction count.
- Reserved opcode 1110: DONE after 2 cycles, no Rin/Rout/Ain/Gin. With ALU_CTRL_ERR_FLAG_EN, ERR=1 and it stays high through a following LOAD until RST.
